resp_encode: RTL

Read-response encoder for the UART/SDRAM command path. When a read burst has landed in the read FIFO, this block pops the payload bytes, wraps them in a response frame (header, payload, checksum), and feeds the frame byte by byte to the UART transmitter through a trig/busy handshake. It sits between the SDRAM read FIFO and `uart_tx`. It is the outbound counterpart of the inbound command decoder.

---
 rtl/sdram_uart_pkg.sv | 21 ++
 rtl/resp_encode.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sdram_uart_pkg.sv
// Shared definitions for the UART/SDRAM command path.
//   RSP_HEAD_DEFAULT : default header byte of a read-response frame
//   CMD_WRITE/READ   : inbound command opcodes
//   resp_state_t     : state type of the read-response encoder
package sdram_uart_pkg;

   localparam logic [7:0] RSP_HEAD_DEFAULT = 8'hA5;
   localparam logic [7:0] CMD_WRITE        = 8'h55;
   localparam logic [7:0] CMD_READ         = 8'hAA;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEAD,
      S_FETCH,
      S_LOAD,
      S_SEND,
      S_CSUM,
      S_FINISH
   } resp_state_t;

endpackage

// File: rtl/resp_encode.sv
// Read-response encoder: after a read burst lands in the read FIFO, pops
// PAYLOAD_LEN bytes and sends header, payload and (optionally) a checksum
// byte to the UART transmitter over a trig/busy handshake.
// Ports:
//   sclk, reset             clock, synchronous active-high reset
//   rd_done                 pulse: PAYLOAD_LEN bytes available in the FIFO
//   rfifo_empty/rd_data     read FIFO status and data (standard, non-FWFT)
//   rfifo_rd_en             read FIFO pop, one cycle per byte
//   tx_busy                 UART busy
//   tx_trig/tx_data         UART start pulse and byte (held until next trig)
//   enc_busy                frame in progress
//   resp_done               pulse after the last frame byte is handed off
module resp_encode
   import sdram_uart_pkg::*;
#(
   parameter int unsigned PAYLOAD_LEN = 4,
   parameter logic [7:0]  RSP_HEAD    = RSP_HEAD_DEFAULT,
   parameter bit          CSUM_EN     = 1'b1
) (
   input  logic       sclk,
   input  logic       reset,
   input  logic       rd_done,
   input  logic       rfifo_empty,
   input  logic [7:0] rfifo_rd_data,
   output logic       rfifo_rd_en,
   input  logic       tx_busy,
   output logic       tx_trig,
   output logic [7:0] tx_data,
   output logic       enc_busy,
   output logic       resp_done
);

   localparam logic [7:0] LEN = 8'(PAYLOAD_LEN);

   resp_state_t state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        rd_en_q, rd_en_d;
   logic        tx_trig_q, tx_trig_d;
   logic        enc_busy_q, enc_busy_d;
   logic        resp_done_q, resp_done_d;
   logic        trig_dly_q, trig_dly_d;
   logic        rd_vld_q, rd_vld_d;

   logic        tx_ok;
   logic [7:0]  cnt_inc;
   logic [7:0]  cur_byte;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      byte_d      = byte_q;
      tx_data_d   = tx_data_q;
      tx_trig_d   = 1'b0;
      rd_en_d     = 1'b0;
      enc_busy_d  = enc_busy_q;
      resp_done_d = 1'b0;
      trig_dly_d  = tx_trig_q;
      rd_vld_d    = rd_en_q;
      // busy is ignored while the trig is out and for the cycle after it,
      // so a UART that raises busy one cycle late is never double-triggered
      tx_ok       = !tx_busy && !tx_trig_q && !trig_dly_q;
      cnt_inc     = cnt_q + 8'd1;
      cur_byte    = rd_vld_q ? rfifo_rd_data : byte_q;

      // The FIFO presents popped data the cycle after rd_en is seen, which is
      // the first SEND cycle; the byte is captured and summed there.
      if (rd_vld_q) begin
         byte_d = rfifo_rd_data;
         sum_d  = sum_q + rfifo_rd_data;
      end

      unique case (state_q)
         S_IDLE: begin
            if (rd_done) begin
               state_d    = S_HEAD;
               cnt_d      = '0;
               sum_d      = '0;
               enc_busy_d = 1'b1;
            end
         end
         S_HEAD: begin
            if (tx_ok) begin
               tx_trig_d = 1'b1;
               tx_data_d = RSP_HEAD;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (!rfifo_empty) begin
               rd_en_d = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            state_d = S_SEND;
         end
         S_SEND: begin
            if (tx_ok) begin
               tx_trig_d = 1'b1;
               tx_data_d = cur_byte;
               cnt_d     = cnt_inc;
               if (cnt_inc < LEN) begin
                  state_d = S_FETCH;
               end else begin
                  state_d = CSUM_EN ? S_CSUM : S_FINISH;
               end
            end
         end
         S_CSUM: begin
            if (tx_ok) begin
               tx_trig_d = 1'b1;
               tx_data_d = ~sum_q + 8'd1;
               state_d   = S_FINISH;
            end
         end
         S_FINISH: begin
            // wait out the trig cycle so resp_done follows the guard cycle
            if (!tx_trig_q) begin
               resp_done_d = 1'b1;
               enc_busy_d  = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sclk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         sum_q       <= '0;
         byte_q      <= '0;
         tx_data_q   <= '0;
         rd_en_q     <= 1'b0;
         tx_trig_q   <= 1'b0;
         enc_busy_q  <= 1'b0;
         resp_done_q <= 1'b0;
         trig_dly_q  <= 1'b0;
         rd_vld_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         byte_q      <= byte_d;
         tx_data_q   <= tx_data_d;
         rd_en_q     <= rd_en_d;
         tx_trig_q   <= tx_trig_d;
         enc_busy_q  <= enc_busy_d;
         resp_done_q <= resp_done_d;
         trig_dly_q  <= trig_dly_d;
         rd_vld_q    <= rd_vld_d;
      end
   end

   assign rfifo_rd_en = rd_en_q;
   assign tx_trig     = tx_trig_q;
   assign tx_data     = tx_data_q;
   assign enc_busy    = enc_busy_q;
   assign resp_done   = resp_done_q;

endmodule
